// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: coin constants shared with the accounting stage
package change_dispenser_pkg;
  localparam int kNumCoins = 3;
  localparam int kTotalBits = 31;
  localparam logic [kTotalBits-1:0] kCoinVal0 = 31'd100;
  localparam logic [kTotalBits-1:0] kCoinVal1 = 31'd500;
  localparam logic [kTotalBits-1:0] kCoinVal2 = 31'd1000;
  function automatic logic [kTotalBits-1:0] coin_val(input int k);
    return k == 2 ? kCoinVal2 : k == 1 ? kCoinVal1 : kCoinVal0;
  endfunction
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: refund request and coin hopper handshake
interface change_dispenser_if;
  import change_dispenser_pkg::*;
  logic start;
  logic [kTotalBits-1:0] amount;
  logic coin_ack;
  logic [kNumCoins-1:0] coin;
  logic busy;
  logic done;
  logic [kTotalBits-1:0] shortfall;
  modport master(output start, amount, coin_ack, input coin, busy, done, shortfall);
  modport slave(input start, amount, coin_ack, output coin, busy, done, shortfall);
endinterface

// File: rtl/change_dispenser_coin_inventory.sv
// change_dispenser_coin_inventory: saturating per-denomination coin counters
module change_dispenser_coin_inventory #(
  parameter int NUM = 3,
  parameter int BITS = 8,
  parameter int INIT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [NUM-1:0] inc,
  input  logic [NUM-1:0] dec,
  output logic [NUM-1:0][BITS-1:0] count,
  output logic [NUM-1:0] empty
);
  // refill counts up (saturating), a dispensed coin counts down, both at once cancel
  always_ff @(posedge clk)
    for (int k = 0; k < NUM; k++)
      if (!reset_n) count[k] <= BITS'(INIT);
      else if (inc[k] && !dec[k] && count[k] != '1) count[k] <= count[k] + 1'b1;
      else if (dec[k] && !inc[k]) count[k] <= count[k] - 1'b1;
  for (genvar k = 0; k < NUM; k++) begin : g_empty
    assign empty[k] = ~|count[k];
  end
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays a refund out coin by coin, largest denomination first
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int INV_BITS = 8,
  parameter int INV_INIT = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic [kNumCoins-1:0] refill,
  output logic [kNumCoins-1:0] inv_empty,
  change_dispenser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PICK, EMIT, DONE} state_t;
  state_t state;
  logic [kTotalBits-1:0] remaining;
  logic [kTotalBits-1:0] coin_amt;
  logic [kNumCoins-1:0] pick;
  logic [kNumCoins-1:0] dec;
  logic [kNumCoins-1:0][INV_BITS-1:0] inv_count;
  change_dispenser_coin_inventory #(.NUM(kNumCoins), .BITS(INV_BITS), .INIT(INV_INIT)) u_inv (
    .clk, .reset_n, .inc(refill), .dec, .count(inv_count), .empty(inv_empty)
  );
  // highest affordable, stocked denomination wins; value of the presented coin
  always_comb begin
    pick = '0;
    coin_amt = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      pick = (coin_val(k) <= remaining && inv_count[k] != '0) ? kNumCoins'(1) << k : pick;
      coin_amt = bus.coin[k] ? coin_amt | coin_val(k) : coin_amt;
    end
  end
  assign dec = (state == EMIT && bus.coin_ack) ? bus.coin : '0;
  assign bus.busy = state == PICK || state == EMIT;
  assign bus.done = state == DONE;
  // refund sequencer: pick a coin, hold it until the hopper takes it, repeat
  always_ff @(posedge clk)
    if (!reset_n) begin
      state <= IDLE;
      remaining <= '0;
      bus.coin <= '0;
      bus.shortfall <= '0;
    end else
      case (state)
        IDLE: if (bus.start) begin
          remaining <= bus.amount;
          bus.shortfall <= '0;
          state <= bus.amount != '0 ? PICK : DONE;
        end
        PICK: if (|pick) begin
          bus.coin <= pick;
          state <= EMIT;
        end else begin
          bus.shortfall <= remaining;
          remaining <= '0;
          state <= DONE;
        end
        EMIT: if (bus.coin_ack) begin
          remaining <= remaining - coin_amt;
          bus.coin <= '0;
          state <= PICK;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed checks of refund sequencing, inventory and reset
module tb_change_dispenser;
  logic clk = 0;
  logic reset_n = 0;
  logic [2:0] refill_a = 0;
  logic [2:0] empty_a, empty_b;
  int checks = 0;
  int failures = 0;
  int cseq[7] = '{4, 0, 2, 0, 1, 0, 0};
  int bseq[7] = '{1, 1, 1, 1, 1, 1, 0};
  int dseq[7] = '{0, 0, 0, 0, 0, 0, 1};
  change_dispenser_if ia();
  change_dispenser_if ib();
  change_dispenser dut_a (.clk, .reset_n, .refill(refill_a), .inv_empty(empty_a), .bus(ia));
  change_dispenser #(.INV_INIT(1)) dut_b (.clk, .reset_n, .refill(3'b000), .inv_empty(empty_b), .bus(ib));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_a(input logic [30:0] amt);
    ia.amount = amt;
    ia.start = 1;
    tick();
    ia.start = 0;
  endtask
  initial begin
    ia.start = 0; ia.amount = 0; ia.coin_ack = 0;
    ib.start = 0; ib.amount = 0; ib.coin_ack = 0;
    tick(2);
    check("rst_coin", 32'(ia.coin), 0);
    check("rst_busy", 32'(ia.busy), 0);
    check("rst_done", 32'(ia.done), 0);
    check("rst_short", 32'(ia.shortfall), 0);
    check("rst_inv", 32'(dut_a.u_inv.count), 32'h0a0a0a);
    reset_n = 1;
    ia.coin_ack = 1;
    start_a(1600);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("r1600_coin%0d", i), 32'(ia.coin), cseq[i]);
      check($sformatf("r1600_busy%0d", i), 32'(ia.busy), bseq[i]);
      check($sformatf("r1600_done%0d", i), 32'(ia.done), dseq[i]);
    end
    check("r1600_short", 32'(ia.shortfall), 0);
    check("r1600_inv", 32'(dut_a.u_inv.count), 32'h090909);
    tick();
    check("r1600_done_end", 32'(ia.done), 0);
    start_a(0);
    check("r0_done", 32'(ia.done), 1);
    check("r0_busy", 32'(ia.busy), 0);
    check("r0_coin", 32'(ia.coin), 0);
    check("r0_short", 32'(ia.shortfall), 0);
    tick();
    check("r0_done_end", 32'(ia.done), 0);
    ib.coin_ack = 1;
    ib.amount = 2150;
    ib.start = 1;
    tick();
    ib.start = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("r2150_coin%0d", i), 32'(ib.coin), cseq[i]);
    end
    check("r2150_done", 32'(ib.done), 1);
    check("r2150_short", 32'(ib.shortfall), 550);
    check("r2150_empty", 32'(empty_b), 7);
    reset_n = 0;
    ia.coin_ack = 0;
    tick();
    reset_n = 1;
    start_a(500);
    tick();
    check("slow_coin_first", 32'(ia.coin), 2);
    for (int i = 0; i < 5; i++) begin
      ia.start = i == 2;
      ia.amount = 1000;
      tick();
      check($sformatf("slow_coin%0d", i), 32'(ia.coin), 2);
      check($sformatf("slow_inv%0d", i), 32'(dut_a.u_inv.count[1]), 10);
    end
    ia.start = 0;
    ia.coin_ack = 1;
    tick();
    ia.coin_ack = 0;
    check("slow_ack_coin", 32'(ia.coin), 0);
    check("slow_ack_inv", 32'(dut_a.u_inv.count[1]), 9);
    tick();
    check("slow_done", 32'(ia.done), 1);
    check("slow_short", 32'(ia.shortfall), 0);
    tick(2);
    check("slow_no_restart_busy", 32'(ia.busy), 0);
    check("slow_no_restart_coin", 32'(ia.coin), 0);
    check("slow_inv2", 32'(dut_a.u_inv.count[2]), 10);
    reset_n = 0;
    tick();
    reset_n = 1;
    start_a(100);
    tick();
    check("rf_coin", 32'(ia.coin), 1);
    ia.coin_ack = 1;
    refill_a = 3'b001;
    tick();
    ia.coin_ack = 0;
    refill_a = 0;
    check("rf_same_cycle_inv0", 32'(dut_a.u_inv.count[0]), 10);
    tick(2);
    refill_a = 3'b001;
    tick(244);
    check("rf_inv0_254", 32'(dut_a.u_inv.count[0]), 254);
    tick();
    check("rf_inv0_255", 32'(dut_a.u_inv.count[0]), 255);
    tick(2);
    check("rf_inv0_sat", 32'(dut_a.u_inv.count[0]), 255);
    refill_a = 0;
    check("rf_empty", 32'(empty_a), 0);
    reset_n = 0;
    tick();
    reset_n = 1;
    ia.coin_ack = 1;
    start_a(1600);
    tick(2);
    check("abort_inv2", 32'(dut_a.u_inv.count[2]), 9);
    tick();
    check("abort_coin_pre", 32'(ia.coin), 2);
    reset_n = 0;
    ia.coin_ack = 0;
    tick();
    check("abort_coin", 32'(ia.coin), 0);
    check("abort_busy", 32'(ia.busy), 0);
    check("abort_done", 32'(ia.done), 0);
    check("abort_inv", 32'(dut_a.u_inv.count), 32'h0a0a0a);
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_no_done%0d", i), 32'(ia.done), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
